// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan controller: shares one external BCD decoder
// across NUM_DIGITS common-anode positions with blanking, blink and zero suppression.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lead,
  output logic                    load_ack,
  output logic [3:0]              bcd,
  input  logic [6:0]              seg7_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int TICK_W  = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int IDX_W   = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST       = TICK_W'(REFRESH_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_BLANK_LAST = TICK_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST        = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST      = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]         SEG_OFF         = 7'h7F;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_e;

  state_e                  state_q, state_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_out_q, seg_d;

  logic [3:0]              shadow_digits_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   shadow_blink_q;
  logic                    shadow_lead_q;
  logic                    load_pend_q;
  logic [BLINK_W-1:0]      blink_cnt_q;
  logic                    blink_phase_q;

  logic                    slot_end;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   suppress;

  assign slot_end   = (tick_q == TICK_LAST);
  assign frame_done = slot_end && (idx_q == IDX_LAST);
  // A load arriving in the frame_done cycle itself is honoured without waiting a frame.
  assign capture    = frame_done && (load_pend_q || load);
  assign load_ack   = capture;

  assign bcd     = shadow_digits_q[idx_q];
  assign seg_out = seg_out_q;
  assign an      = an_q;

  // Slot sequencing: tick/idx counters and the BLANK/DRIVE phase within a slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tick_d  = tick_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (slot_end) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      ST_BLANK: if (tick_q == TICK_BLANK_LAST) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_end)                  state_d = ST_BLANK;
      default:                                 state_d = ST_BLANK;
    endcase
  end

  // Anodes are registered from next-state values so they drop with the idx change.
  always_comb begin
    an_d = '1;
    if (state_d == ST_DRIVE) an_d[idx_d] = 1'b0;
  end

  // Digit i>0 is a leading zero when it and every digit above it read zero.
  always_comb begin : lead_zero
    logic zero_above;
    zero_above = 1'b1;
    suppress   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above  = zero_above && (shadow_digits_q[i] == 4'h0);
      suppress[i] = shadow_lead_q && zero_above;
    end
  end

  always_comb begin
    seg_d = seg7_in;
    if ((blink_phase_q && shadow_blink_q[idx_q]) || suppress[idx_q]) seg_d = SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      tick_q        <= '0;
      idx_q         <= '0;
      an_q          <= '1;
      seg_out_q     <= SEG_OFF;
      load_pend_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_blink_q <= '0;
      shadow_lead_q  <= 1'b0;
      // NOTE: the shadow digit array is reset deliberately: bcd must present 4'h0 out of reset.
      for (int i = 0; i < NUM_DIGITS; i++) shadow_digits_q[i] <= 4'h0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_out_q <= seg_d;

      if (capture) begin
        load_pend_q    <= 1'b0;
        shadow_blink_q <= blink_mask;
        shadow_lead_q  <= blank_lead;
        for (int i = 0; i < NUM_DIGITS; i++) shadow_digits_q[i] <= digits[4*i +: 4];
      end else if (load) begin
        load_pend_q <= 1'b1;
      end

      if (frame_done) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan controller for the clock's common-anode seven-segment bank. It shares a single external BCD-to-seven-segment decoder between `NUM_DIGITS` digit positions. Each cycle it presents one digit's BCD code to the decoder, registers the returned segment pattern, and drives one anode at a time. It also provides blanking against ghosting, tear-free frame loading, per-digit blink and leading-zero suppression. It sits between the timekeeping counters and the display pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digit positions scanned; index 0 is the least significant.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES` + 2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `BLINK_FRAMES`, 100: full scan frames per blink half-period; must be ≥ 1.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `digits`  in  4*NUM_DIGITS  BCD codes; digit i is in bits [4i+3:4i].
- `load`  in  1  request to capture `digits`, `blink_mask`, `blank_lead` into shadow registers.
- `blink_mask`  in  NUM_DIGITS  bit i=1 makes digit i blink.
- `blank_lead`  in  1  suppress leading zeros.
- `load_ack`  out  1  one-cycle pulse when the shadow capture happens.
- `bcd`  out  4  code presented to the shared decoder.
- `seg7_in`  in  7  decoder result, active-low segments, combinational from `bcd`.
- `seg_out`  out  7  registered segment drive, active-low.
- `an`  out  NUM_DIGITS  anode enables, active-low, at most one low.
- `frame_done`  out  1  one-cycle pulse at the end of each full frame.

## Operation
- Registers: `tick` (0..REFRESH_DIV-1), `idx` (0..NUM_DIGITS-1), `state` ∈ {BLANK, DRIVE}, shadow copies of the inputs, `load_pend`, `blink_cnt` (0..BLINK_FRAMES-1), `blink_phase`.
- `tick` increments every cycle and wraps to 0 after REFRESH_DIV-1. On that wrap, `idx` advances; it wraps from NUM_DIGITS-1 to 0.
- State machine:
  - BLANK while `tick` < BLANK_CYCLES.
  - DRIVE for the rest of the slot.
  - DRIVE→BLANK on the `tick` wrap.
- `bcd` = shadow digit[`idx`], combinational from registers, and valid throughout the slot.
- In BLANK: `an` is all ones, and `seg_out` is loaded with the masked `seg7_in` every cycle, so the pattern is settled before DRIVE.
- In DRIVE: `an[idx]`=0 and all other anodes are 1; `seg_out` keeps updating from the masked `seg7_in`.
- Masking: `seg_out` is forced to 7'h7F when either condition holds:
  - `blink_phase`=1 and shadow `blink_mask[idx]`=1; or
  - digit `idx` is a suppressed leading zero.
- Leading-zero rule, applied only when shadow `blank_lead`=1: digit i>0 is suppressed if it and every digit above it are 4'h0. Digit 0 is never suppressed.
- Load handshake:
  - `load`=1 sets `load_pend`.
  - Shadow capture happens on the cycle `frame_done` fires. It takes the values present on `digits`/`blink_mask`/`blank_lead` in that cycle, and `load_ack` pulses in the same cycle.
  - Capture clears `load_pend`.
  - Repeated `load` before capture is harmless; only one capture and one ack result.
  - `load` asserted in the capture cycle itself is captured and acknowledged in that cycle.
- Blink: on each `frame_done`, `blink_cnt` increments. When it wraps from BLINK_FRAMES-1 to 0, `blink_phase` toggles.
- Codes 4'hA–4'hF are passed to the decoder unchanged; no clamping.

## Timing
- Reset values:
  - `tick`=0, `idx`=0, `state`=BLANK.
  - `an`=all ones, `seg_out`=7'h7F.
  - `bcd`=4'h0, because the shadow digits reset to 0.
  - `load_ack`=0, `frame_done`=0.
  - `blink_phase`=0, `blink_cnt`=0, `load_pend`=0.
  - Shadow `blink_mask`=0, shadow `blank_lead`=0.
- Reset mid-slot or mid-frame aborts immediately; the first slot after reset is digit 0 starting in BLANK. A pending load is discarded.
- `frame_done` is high during the cycle where `tick`=REFRESH_DIV-1 and `idx`=NUM_DIGITS-1.
- `seg_out` lags `bcd` by one cycle. The first DRIVE cycle therefore shows the pattern for the current `idx`.
- The `an` transition is registered, and anodes go high in the same cycle `idx` changes. There is no overlap of two active anodes.
- Frame period = NUM_DIGITS × REFRESH_DIV cycles. Blink half-period = BLINK_FRAMES frames.
- Shadow changes take effect from the slot starting after the capture cycle, so no frame ever mixes old and new data.

## Test plan
Common settings: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, with a reference decoder model on `seg7_in`.
- Reset then load digits=16'h1234 -> `load_ack` at cycle 31. During the next frame, `an` low pattern per slot is 1110, 1101, 1011, 0111 for cycles 2–7 of each slot. `seg_out` is 7'b0011001 (4) in slot 0 and 7'b1111001 (1) in slot 3.
- digits=16'h0005, blank_lead=1, load -> slots 1–3 show `seg_out`=7'h7F and slot 0 shows 7'b0010010. With digits=16'h0000, slot 0 shows 7'b1000000.
- blink_mask=4'b0010 -> digit 1 shows its pattern for frames 0–1, 7'h7F for frames 2–3, then the pattern again. Other digits are unaffected.
- `load` pulsed mid-frame at tick 3 of slot 1, with digits changed afterwards -> no shadow change until the `frame_done` cycle. The captured value is the one present in that cycle, with exactly one `load_ack`.
- `reset` asserted in a DRIVE cycle of slot 2 -> next cycle `an`=4'hF, `seg_out`=7'h7F, `idx`=0, `tick`=0. The pending load is dropped and `blink_phase`=0.
- Across 3 full frames -> `an` never has more than one zero, and `frame_done` pulses every 32 cycles.
